// File: rtl/reg_file_ctx_seq_pkg.sv
// Shared definitions for the PE register-file context sequencer.
//   state_e         : sequencer state (IDLE / RUN / DONE)
//   INST_W_DEF      : default width of the register-file select word
//   R*_SEL_BIT      : position of each register select bit in the word,
//                     word layout is {R0_sel, R1_sel, R2_sel, R3_sel}
//   IDLE_SEL        : select word driven while idle or in reset
//                     (default shift chain, R0 loads din_res)
package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int unsigned INST_W_DEF = 4;

  localparam int unsigned R0_SEL_BIT = 3;
  localparam int unsigned R1_SEL_BIT = 2;
  localparam int unsigned R2_SEL_BIT = 1;
  localparam int unsigned R3_SEL_BIT = 0;

  // Builds a select word from individual register select bits.
  function automatic logic [3:0] sel_word(input logic r0, input logic r1,
                                          input logic r2, input logic r3);
    logic [3:0] w;
    w             = '0;
    w[R0_SEL_BIT] = r0;
    w[R1_SEL_BIT] = r1;
    w[R2_SEL_BIT] = r2;
    w[R3_SEL_BIT] = r3;
    return w;
  endfunction

  localparam logic [3:0] IDLE_SEL = sel_word(1'b0, 1'b0, 1'b0, 1'b0);

endpackage

// File: rtl/reg_file_ctx_seq_ctx_mem.sv
// Context memory for the register-file sequencer: DEPTH x INST_W flop
// array with one synchronous write port and one asynchronous read port.
// Contents are not reset.
//   clk    : clock
//   we     : write strobe
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational)
module ctx_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned INST_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/reg_file_ctx_seq.sv
// Context sequencer driving the 4-bit register-file select word of one PE.
// A small context memory is loaded over the config port while idle; on
// start, entries 0..len-1 are played cycle by cycle for a programmed number
// of iterations, with stall (freeze) and abort (return to idle).
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   cfg_we/addr/data  : context write port, accepted only while idle
//   cfg_ready         : high while idle (config writes accepted)
//   start             : one-cycle run request, ignored outside idle
//   ctx_len, iter_cnt : entries per iteration / iterations, sampled on start
//   stall             : freezes sequencing, masks inst_valid
//   abort             : ends a run immediately without done
//   reg_file_inst     : registered select word to the register file
//   inst_valid        : reg_file_inst is a live context word this cycle
//   pc, iter          : current entry index / completed iterations
//   busy, done        : not idle / one-cycle completion pulse
//   stall_cycles      : stalled RUN cycles, saturating; present only when
//                       REG_FILE_SEQ_STALL_CNT_EN is defined
module reg_file_ctx_seq
  import pe_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned INST_W = INST_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [INST_W-1:0] cfg_data,
  output logic              cfg_ready,
  input  logic              start,
  input  logic [AW:0]       ctx_len,
  input  logic [CNT_W-1:0]  iter_cnt,
  input  logic              stall,
  input  logic              abort,
  output logic [INST_W-1:0] reg_file_inst,
  output logic              inst_valid,
  output logic [AW-1:0]     pc,
  output logic [CNT_W-1:0]  iter,
  output logic              busy,
  output logic              done
`ifdef REG_FILE_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam logic [AW:0]       DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [INST_W-1:0] IDLE_WORD = INST_W'(IDLE_SEL);

  state_e            state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0]  iter_q, iter_d;
  logic [AW-1:0]     last_pc_q, last_pc_d;
  logic [CNT_W-1:0]  last_iter_q, last_iter_d;

  logic [AW:0]       len_clamped;
  logic [AW-1:0]     rd_addr;
  logic [INST_W-1:0] rd_data;
  logic              mem_we;

  assign mem_we = cfg_we && (state_q == ST_IDLE);

  ctx_mem #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .INST_W (INST_W)
  ) u_ctx_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign len_clamped = (ctx_len > DEPTH_L) ? DEPTH_L : ctx_len;

  // Next-state logic. The memory read address is steered to the entry that
  // will be on reg_file_inst next cycle, so the word is registered straight
  // from the asynchronous read port. The run bounds are stored as last
  // indices (len-1, iter_cnt-1) so end-of-run detection is a plain compare.
  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    pc_d        = pc_q;
    iter_d      = iter_q;
    last_pc_d   = last_pc_q;
    last_iter_d = last_iter_q;
    rd_addr     = '0;

    case (state_q)
      ST_IDLE: begin
        inst_d  = IDLE_WORD;
        valid_d = 1'b0;
        if (start) begin
          pc_d   = '0;
          iter_d = '0;
          if ((len_clamped == '0) || (iter_cnt == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_RUN;
            last_pc_d   = AW'(len_clamped - 1'b1);
            last_iter_d = iter_cnt - 1'b1;
            rd_addr     = '0;
            inst_d      = rd_data;
            valid_d     = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          inst_d  = IDLE_WORD;
          valid_d = 1'b0;
          pc_d    = '0;
          iter_d  = '0;
        end else if (!stall) begin
          if (pc_q == last_pc_q) begin
            if (iter_q == last_iter_q) begin
              state_d = ST_DONE;
              inst_d  = IDLE_WORD;
              valid_d = 1'b0;
              pc_d    = '0;
              iter_d  = iter_q + 1'b1;
            end else begin
              rd_addr = '0;
              inst_d  = rd_data;
              pc_d    = '0;
              iter_d  = iter_q + 1'b1;
            end
          end else begin
            rd_addr = pc_q + 1'b1;
            inst_d  = rd_data;
            pc_d    = pc_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        inst_d  = IDLE_WORD;
        valid_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        inst_d  = IDLE_WORD;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      inst_q      <= IDLE_WORD;
      valid_q     <= 1'b0;
      pc_q        <= '0;
      iter_q      <= '0;
      last_pc_q   <= '0;
      last_iter_q <= '0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      iter_q      <= iter_d;
      last_pc_q   <= last_pc_d;
      last_iter_q <= last_iter_d;
    end
  end

  // The word is held during stall but is not consumed, hence the mask.
  assign reg_file_inst = inst_q;
  assign inst_valid    = valid_q && !stall;
  assign pc            = pc_q;
  assign iter          = iter_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign cfg_ready     = (state_q == ST_IDLE);

`ifdef REG_FILE_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      stall_cnt_d = '0;
    end else if ((state_q == ST_RUN) && stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_reg_file_ctx_seq.sv
// Self-checking bench for reg_file_ctx_seq: directed stimulus, a run-level
// reference model compared every cycle, and literal spot checks.
module tb_reg_file_ctx_seq;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned INST_W = 4;
  localparam int unsigned CNT_W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [INST_W-1:0] cfg_data;
  logic              cfg_ready;
  logic              start;
  logic [AW:0]       ctx_len;
  logic [CNT_W-1:0]  iter_cnt;
  logic              stall;
  logic              abort;
  logic [INST_W-1:0] reg_file_inst;
  logic              inst_valid;
  logic [AW-1:0]     pc;
  logic [CNT_W-1:0]  iter;
  logic              busy;
  logic              done;
`ifdef REG_FILE_SEQ_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  reg_file_ctx_seq #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .INST_W (INST_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_ready     (cfg_ready),
    .start         (start),
    .ctx_len       (ctx_len),
    .iter_cnt      (iter_cnt),
    .stall         (stall),
    .abort         (abort),
    .reg_file_inst (reg_file_inst),
    .inst_valid    (inst_valid),
    .pc            (pc),
    .iter          (iter),
    .busy          (busy),
    .done          (done)
`ifdef REG_FILE_SEQ_STALL_CNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is len*n word slots; slot k presents entry
  // k%len during iteration k/len. Stalled cycles do not consume a slot.
  logic [3:0] ctx_m [16];
  int         m_state = 0;   // 0 idle, 1 run, 2 done
  int         m_len, m_n, m_idx;
  bit         m_normal, m_pi_zero, m_live;
  logic [31:0] m_stall;
  int         m_pc, m_it;

  always @(posedge clk) begin
    if (rst) begin
      m_live    = 1'b1;
      m_state   = 0;
      m_pi_zero = 1'b1;
      m_idx     = 0;
      m_stall   = 0;
    end else begin
      case (m_state)
        0: begin
          if (cfg_we) ctx_m[cfg_addr] = cfg_data;
          if (start) begin
            m_stall = 0;
            m_len   = (int'(ctx_len) > 16) ? 16 : int'(ctx_len);
            m_n     = int'(iter_cnt);
            m_idx   = 0;
            if (m_len == 0 || m_n == 0) begin
              m_state  = 2;
              m_normal = 1'b0;
            end else begin
              m_state = 1;
            end
          end
        end
        1: begin
          if (stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
          if (abort) begin
            m_state   = 0;
            m_pi_zero = 1'b1;
          end else if (!stall) begin
            m_idx = m_idx + 1;
            if (m_idx == m_len * m_n) begin
              m_state  = 2;
              m_normal = 1'b1;
            end
          end
        end
        default: begin
          m_state   = 0;
          m_pi_zero = 1'b0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      case (m_state)
        0: begin
          chk("idle_inst", 32'(reg_file_inst), 0);
          chk("idle_valid", 32'(inst_valid), 0);
          chk("idle_busy", 32'(busy), 0);
          chk("idle_done", 32'(done), 0);
          chk("idle_cfg_ready", 32'(cfg_ready), 1);
          if (m_pi_zero) begin
            chk("idle_pc", 32'(pc), 0);
            chk("idle_iter", 32'(iter), 0);
          end
        end
        1: begin
          m_pc = m_idx % m_len;
          m_it = m_idx / m_len;
          chk("run_inst", 32'(reg_file_inst), 32'(ctx_m[m_pc]));
          chk("run_valid", 32'(inst_valid), 32'(!stall));
          chk("run_pc", 32'(pc), 32'(m_pc));
          chk("run_iter", 32'(iter), 32'(m_it));
          chk("run_busy", 32'(busy), 1);
          chk("run_done", 32'(done), 0);
          chk("run_cfg_ready", 32'(cfg_ready), 0);
        end
        default: begin
          chk("done_inst", 32'(reg_file_inst), 0);
          chk("done_valid", 32'(inst_valid), 0);
          chk("done_busy", 32'(busy), 1);
          chk("done_done", 32'(done), 1);
          chk("done_cfg_ready", 32'(cfg_ready), 0);
          if (m_normal) chk("done_iter", 32'(iter), 32'(m_n));
        end
      endcase
`ifdef REG_FILE_SEQ_STALL_CNT_EN
      chk("stall_cycles", stall_cycles, m_stall);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = INST_W'(d);
    tick();
    cfg_we   = 1'b0;
  endtask

  // Returns one edge after start is sampled, i.e. inside cycle t+1.
  task automatic run_start(input int len, input int n);
    start    = 1'b1;
    ctx_len  = (AW+1)'(len);
    iter_cnt = CNT_W'(n);
    tick();
    start    = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  logic [3:0] t1_exp [8];
  int         nvalid;
  bit         seen_done;

  initial begin
    t1_exp = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1};
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; ctx_len = '0; iter_cnt = '0; stall = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset values
    look();
    chk("rst_inst", 32'(reg_file_inst), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_iter", 32'(iter), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);

    for (int i = 0; i < 16; i++) cfg_write(i, i);

    // Basic run: 8,4,2,1 twice, done at t+9
    cfg_write(0, 8); cfg_write(1, 4); cfg_write(2, 2); cfg_write(3, 1);
    run_start(4, 2);
    for (int k = 0; k < 8; k++) begin
      look();
      chk("t1_word", 32'(reg_file_inst), 32'(t1_exp[k]));
      chk("t1_valid", 32'(inst_valid), 1);
      chk("t1_pc", 32'(pc), 32'(k % 4));
      tick();
    end
    look();
    chk("t1_done", 32'(done), 1);
    chk("t1_iter", 32'(iter), 2);
    tick();
    look();
    chk("t1_idle_busy", 32'(busy), 0);

    // Stall three cycles at pc=2
    run_start(4, 1);
    tick(); tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      look();
      chk("t2_hold_word", 32'(reg_file_inst), 2);
      chk("t2_hold_valid", 32'(inst_valid), 0);
      tick();
    end
    stall = 1'b0;
    look();
    chk("t2_resume_word", 32'(reg_file_inst), 2);
    chk("t2_resume_valid", 32'(inst_valid), 1);
    tick();
    look();
    chk("t2_last_word", 32'(reg_file_inst), 1);
    chk("t2_last_pc", 32'(pc), 3);
    tick();
    look();
    chk("t2_done", 32'(done), 1);
    tick();

    // Degenerate starts
    run_start(4, 0);
    look();
    chk("t3a_done", 32'(done), 1);
    chk("t3a_busy", 32'(busy), 1);
    chk("t3a_valid", 32'(inst_valid), 0);
    tick();
    look();
    chk("t3a_busy_after", 32'(busy), 0);
    run_start(0, 3);
    look();
    chk("t3b_done", 32'(done), 1);
    chk("t3b_valid", 32'(inst_valid), 0);
    tick();
    look();
    chk("t3b_busy_after", 32'(busy), 0);

    // Config write in RUN ignored, abort with stall at pc=1
    run_start(4, 2);
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = 4'h7;
    tick();
    cfg_we = 1'b0; abort = 1'b1; stall = 1'b1;
    look();
    chk("t4_pc_at_abort", 32'(pc), 1);
    tick();
    abort = 1'b0; stall = 1'b0;
    look();
    chk("t4_busy", 32'(busy), 0);
    chk("t4_inst", 32'(reg_file_inst), 0);
    chk("t4_done", 32'(done), 0);
    tick();
    run_start(1, 1);
    look();
    chk("t4_ctx0_kept", 32'(reg_file_inst), 8);
    tick();
    tick();

    // Reset mid-run, then single-entry context
    run_start(4, 2);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    look();
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_inst", 32'(reg_file_inst), 0);
    chk("t5_rst_pc", 32'(pc), 0);
    chk("t5_rst_done", 32'(done), 0);
    tick();
    cfg_write(0, 15);
    run_start(1, 3);
    for (int k = 0; k < 3; k++) begin
      look();
      chk("t5_word", 32'(reg_file_inst), 32'hF);
      chk("t5_valid", 32'(inst_valid), 1);
      chk("t5_iter", 32'(iter), 32'(k));
      tick();
    end
    look();
    chk("t5_done", 32'(done), 1);
    chk("t5_iter_final", 32'(iter), 3);
    tick();

    // ctx_len above DEPTH clamps to DEPTH
    nvalid = 0;
    seen_done = 1'b0;
    run_start(20, 1);
    for (int c = 0; c < 40; c++) begin
      look();
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (inst_valid) nvalid++;
      tick();
    end
    chk("clamp_done_seen", 32'(seen_done), 1);
    chk("clamp_count", 32'(nvalid), 16);
    tick();

`ifdef REG_FILE_SEQ_STALL_CNT_EN
    // Five stall cycles spread over a len=2, iter=4 run
    seen_done = 1'b0;
    run_start(2, 4);
    for (int c = 0; c < 30; c++) begin
      stall = (c == 1 || c == 3 || c == 4 || c == 6 || c == 9);
      look();
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      tick();
    end
    stall = 1'b0;
    chk("sc_done_seen", 32'(seen_done), 1);
    chk("sc_after_done", stall_cycles, 5);
    tick();
    look();
    chk("sc_idle_hold", stall_cycles, 5);
    tick();
    run_start(2, 1);
    look();
    chk("sc_cleared", stall_cycles, 0);
    tick(); tick(); tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
